rcv_control: RTL and testbench

Receive control unit for the UART receiver. Sequences one serial frame (start, 8 data bits, stop) by gating the bit-period timer, checks the stop bit, and commands the receive buffer load. Owns the host-facing status flags: data_ready, overrun_error, framing_error. Sits between the start-bit edge detector, the timer, the shift register and the receive buffer.

---
 rtl/rcv_pkg.sv | 13 +
 rtl/rcv_status.sv | 47 ++++
 rtl/rcv_control.sv | 85 ++++++++
 tb/tb_rcv_control.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared types for the UART receive control path.
// The state encoding is exported so that monitors can decode FSM state.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        RECEIVE    = 3'd2,
        STOP_CHECK = 3'd3,
        LOAD       = 3'd4
    } rcv_state_t;

endpackage

// File: rtl/rcv_status.sv
// Host-facing receive buffer status: data_ready and overrun_error.
// A load that coincides with a host read counts as consumed, not as an overrun.
module rcv_status (
    input  logic clk,
    input  logic n_rst,
    input  logic load_buffer,
    input  logic data_read,
    output logic data_ready,
    output logic overrun_error
);

    logic ready_reg;
    logic ready_next;
    logic overrun_reg;
    logic overrun_next;

    always_comb begin
        ready_next   = ready_reg;
        overrun_next = overrun_reg;

        if (load_buffer) begin
            ready_next = 1'b1;
        end else if (data_read) begin
            ready_next = 1'b0;
        end

        if (load_buffer && ready_reg && !data_read) begin
            overrun_next = 1'b1;
        end else if (data_read) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            ready_reg   <= ready_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data_ready    = ready_reg;
    assign overrun_error = overrun_reg;

endmodule

// File: rtl/rcv_control.sv
// UART receive control: sequences one frame, checks the stop bit and
// strobes the receive buffer load; owns the framing-error flag.
module rcv_control
    import rcv_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic packet_done,
    input  logic stop_bit,
    input  logic data_read,
    output logic enable_timer,
    output logic load_buffer,
    output logic data_ready,
    output logic overrun_error,
    output logic framing_error
);

    rcv_state_t state_reg;
    rcv_state_t state_next;
    logic       framing_reg;
    logic       framing_next;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            framing_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            framing_reg <= framing_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        framing_next = framing_reg;
        enable_timer = 1'b0;
        load_buffer  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_bit_detected) begin
                    state_next = START;
                end
            end
            START: begin
                framing_next = 1'b0;
                state_next   = RECEIVE;
            end
            RECEIVE: begin
                enable_timer = 1'b1;
                if (packet_done) begin
                    state_next = STOP_CHECK;
                end
            end
            STOP_CHECK: begin
                if (stop_bit) begin
                    state_next = LOAD;
                end else begin
                    framing_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            LOAD: begin
                load_buffer = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign framing_error = framing_reg;

    rcv_status u_status (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_buffer   (load_buffer),
        .data_read     (data_read),
        .data_ready    (data_ready),
        .overrun_error (overrun_error)
    );

endmodule

// File: tb/tb_rcv_control.sv
// Self-checking bench for rcv_control: frame sequencing, stop-bit checking,
// status flags and reset, with a queue of expected post-frame flag values.
module tb_rcv_control;

    logic clk;
    logic n_rst;
    logic start_bit_detected;
    logic packet_done;
    logic stop_bit;
    logic data_read;
    logic enable_timer;
    logic load_buffer;
    logic data_ready;
    logic overrun_error;
    logic framing_error;

    typedef struct packed {
        logic ready;
        logic overrun;
        logic framing;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    logic model_ready;
    logic model_overrun;
    logic model_framing;

    rcv_control dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .stop_bit           (stop_bit),
        .data_read          (data_read),
        .enable_timer       (enable_timer),
        .load_buffer        (load_buffer),
        .data_ready         (data_ready),
        .overrun_error      (overrun_error),
        .framing_error      (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // One complete frame: start pulse, body cycles in RECEIVE, packet_done,
    // stop check and (for a good stop bit) the load cycle.
    task automatic do_frame(input string name, input logic sb, input logic rd_at_load,
                            input int body, input logic spurious);
        int   en_cnt;
        logic load_seen;
        exp_t e;
        exp_t got;

        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 0;
        tests_run++;
        if (enable_timer !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s start_en: got %b expected 0", name, enable_timer);
        end
        tick();
        tests_run++;
        if (framing_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s fe_clear_at_start: got %b expected 0", name, framing_error);
        end
        model_framing = 1'b0;

        en_cnt    = 0;
        load_seen = 1'b0;
        for (int i = 0; i < body; i++) begin
            if (enable_timer === 1'b1) en_cnt++;
            if (load_buffer !== 1'b0) load_seen = 1'b1;
            start_bit_detected = (spurious && i == body / 2);
            tick();
        end
        start_bit_detected = 1'b0;
        tests_run++;
        if (en_cnt != body || load_seen) begin
            tests_failed++;
            $display("[TB] FAIL %s receive: enable cycles %0d load %b expected %0d and 0",
                     name, en_cnt, load_seen, body);
        end

        packet_done = 1'b1;
        stop_bit    = sb;
        tick();
        packet_done = 1'b0;
        tests_run++;
        if (enable_timer !== 1'b0 || load_buffer !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s stop_check: en %b load %b expected 0 0",
                     name, enable_timer, load_buffer);
        end

        if (sb) begin
            e.overrun = (model_ready && !rd_at_load) ? 1'b1 : (rd_at_load ? 1'b0 : model_overrun);
            e.ready   = 1'b1;
            e.framing = 1'b0;
        end else begin
            e.overrun = model_overrun;
            e.ready   = model_ready;
            e.framing = 1'b1;
        end
        exp_q.push_back(e);
        model_ready   = e.ready;
        model_overrun = e.overrun;
        model_framing = e.framing;

        tick();
        tests_run++;
        if (load_buffer !== sb) begin
            tests_failed++;
            $display("[TB] FAIL %s load_strobe: got %b expected %b", name, load_buffer, sb);
        end
        if (sb) begin
            data_read = rd_at_load;
            tick();
            data_read = 1'b0;
        end
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: queue empty", name);
        end else begin
            got = exp_q.pop_front();
            if (data_ready !== got.ready || overrun_error !== got.overrun ||
                framing_error !== got.framing || load_buffer !== 1'b0 || enable_timer !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL %s flags: rdy %b ovr %b fe %b load %b en %b expected %b %b %b 0 0",
                         name, data_ready, overrun_error, framing_error, load_buffer, enable_timer,
                         got.ready, got.overrun, got.framing);
            end
        end
        $display("[TB] frame %s stop=%b read_at_load=%b -> rdy %b ovr %b fe %b",
                 name, sb, rd_at_load, data_ready, overrun_error, framing_error);
    endtask

    task automatic host_read(input string name);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        model_ready   = 1'b0;
        model_overrun = 1'b0;
        check_bit({name, "_ready"}, data_ready, model_ready);
        check_bit({name, "_overrun"}, overrun_error, model_overrun);
        check_bit({name, "_fe_kept"}, framing_error, model_framing);
        $display("[TB] read %s -> rdy %b ovr %b", name, data_ready, overrun_error);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        model_ready = 0; model_overrun = 0; model_framing = 0;
        check_bit("reset_en", enable_timer, 1'b0);
        check_bit("reset_load", load_buffer, 1'b0);
        check_bit("reset_ready", data_ready, 1'b0);
        check_bit("reset_overrun", overrun_error, 1'b0);
        check_bit("reset_fe", framing_error, 1'b0);
        $display("[TB] reset -> en %b load %b rdy %b ovr %b fe %b",
                 enable_timer, load_buffer, data_ready, overrun_error, framing_error);
    endtask

    task automatic test_good_frame();
        repeat (3) tick();
        do_frame("good", 1'b1, 1'b0, 90, 1'b0);
    endtask

    task automatic test_bad_stop();
        host_read("pre_bad");
        do_frame("bad_stop", 1'b0, 1'b0, 90, 1'b0);
        tick();
        check_bit("bad_stop_fe_hold", framing_error, 1'b1);
        host_read("bad_stop_read");
    endtask

    task automatic test_overrun();
        do_frame("ovr_first", 1'b1, 1'b0, 20, 1'b0);
        do_frame("ovr_second", 1'b1, 1'b0, 20, 1'b0);
        host_read("ovr_read");
    endtask

    task automatic test_load_with_read();
        do_frame("lwr_first", 1'b1, 1'b0, 15, 1'b0);
        do_frame("lwr_second", 1'b1, 1'b0, 15, 1'b0);
        do_frame("lwr_coincident", 1'b1, 1'b1, 15, 1'b0);
    endtask

    task automatic test_spurious();
        int extra_loads;
        extra_loads = 0;
        packet_done = 1'b1;
        tick();
        packet_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (load_buffer !== 1'b0 || enable_timer !== 1'b0) extra_loads++;
            tick();
        end
        tests_run++;
        if (extra_loads != 0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_packet_done: %0d active cycles expected 0", extra_loads);
        end
        $display("[TB] spurious packet_done in IDLE -> active cycles %0d", extra_loads);
        do_frame("spurious_start", 1'b1, 1'b0, 30, 1'b1);
        tick();
        check_bit("spurious_start_idle_en", enable_timer, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        do_frame("pre_reset_bad", 1'b0, 1'b0, 10, 1'b0);
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        repeat (35) tick();
        check_bit("mid_frame_running", enable_timer, 1'b1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        model_ready = 0; model_overrun = 0; model_framing = 0;
        check_bit("mid_reset_en", enable_timer, 1'b0);
        check_bit("mid_reset_ready", data_ready, 1'b0);
        check_bit("mid_reset_overrun", overrun_error, 1'b0);
        check_bit("mid_reset_fe", framing_error, 1'b0);
        tick();
        check_bit("mid_reset_stays_idle", enable_timer, 1'b0);
        $display("[TB] reset mid-frame -> en %b rdy %b ovr %b fe %b",
                 enable_timer, data_ready, overrun_error, framing_error);
    endtask

    task automatic test_back_to_back();
        do_frame("b2b_1", 1'b1, 1'b0, 12, 1'b0);
        do_frame("b2b_2", 1'b0, 1'b0, 12, 1'b0);
        do_frame("b2b_3", 1'b1, 1'b1, 12, 1'b0);
        host_read("b2b_read");
    endtask

    initial begin
        n_rst              = 1'b0;
        start_bit_detected = 1'b0;
        packet_done        = 1'b0;
        stop_bit           = 1'b1;
        data_read          = 1'b0;
        model_ready        = 1'b0;
        model_overrun      = 1'b0;
        model_framing      = 1'b0;

        test_reset();
        test_good_frame();
        test_bad_stop();
        test_overrun();
        test_load_with_read();
        test_spurious();
        test_reset_mid_frame();
        test_back_to_back();

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
